// File: rtl/song_recorder_if.sv
// Bus bundle between the song recorder and its controller/playback logic.
// The master drives record controls and the read index; the slave returns track data and status.
interface song_recorder_if #(
   parameter int ADDR_BITS   = 6,
   parameter int OCTAVE_BITS = 3,
   parameter int NOTE_BITS   = 3,
   parameter int LENGTH_BITS = 3,
   parameter int GAP_BITS    = 8
);
   logic                   en;
   logic                   start;
   logic                   stop;
   logic                   tick;
   logic                   note_valid;
   logic [OCTAVE_BITS-1:0] octave;
   logic [NOTE_BITS-1:0]   note;
   logic [LENGTH_BITS-1:0] length;
   logic [ADDR_BITS-1:0]   rd_addr;
   logic [OCTAVE_BITS-1:0] rd_octave;
   logic [NOTE_BITS-1:0]   rd_note;
   logic [LENGTH_BITS-1:0] rd_length;
   logic [GAP_BITS-1:0]    rd_gap;
   logic [ADDR_BITS:0]     track;
   logic [1:0]             state;
   logic                   full;
   logic                   overflow;

   modport master (
      output en, start, stop, tick, note_valid, octave, note, length, rd_addr,
      input  rd_octave, rd_note, rd_length, rd_gap, track, state, full, overflow
   );

   modport slave (
      input  en, start, stop, tick, note_valid, octave, note, length, rd_addr,
      output rd_octave, rd_note, rd_length, rd_gap, track, state, full, overflow
   );
endinterface

// File: rtl/song_recorder.sv
// Free-play note recorder: captures struck notes plus inter-note tick gaps into a track
// buffer and exposes a combinational address-indexed read port for playback.
module song_recorder #(
   parameter int DEPTH       = 64,
   parameter int ADDR_BITS   = 6,
   parameter int OCTAVE_BITS = 3,
   parameter int NOTE_BITS   = 3,
   parameter int LENGTH_BITS = 3,
   parameter int GAP_BITS    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   song_recorder_if.slave    bus
);
   localparam int ENTRY_BITS = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS + GAP_BITS;
   localparam logic [ADDR_BITS:0]  TRACK_FULL = ADDR_BITS'(0) + (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]  TRACK_LAST = (ADDR_BITS+1)'(DEPTH - 1);
   localparam logic [GAP_BITS-1:0] GAP_MAX    = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ARMED  = 2'b01,
      S_RECORD = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS:0]     track_q, track_d;
   logic [GAP_BITS-1:0]    gap_q, gap_d;
   logic                   overflow_q, overflow_d;
   logic                   full_q, full_d;
   logic                   wr_en;
   logic [GAP_BITS-1:0]    wr_gap;
   logic [ENTRY_BITS-1:0]  wr_data;

   // Track storage is deliberately left unreset so it maps onto plain RAM.
   logic [ENTRY_BITS-1:0]  mem [DEPTH];
   logic [ENTRY_BITS-1:0]  rd_entry;
   logic                   rd_hit;

   always_comb begin
      state_d    = state_q;
      track_d    = track_q;
      gap_d      = gap_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      wr_gap     = gap_q;

      if (!bus.en) begin
         state_d = S_IDLE;
         if (bus.note_valid && full_q) overflow_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_d    = S_ARMED;
                  track_d    = '0;
                  overflow_d = 1'b0;
                  gap_d      = '0;
               end else if (bus.note_valid && full_q) begin
                  overflow_d = 1'b1;
               end
            end
            S_ARMED, S_RECORD: begin
               if (bus.note_valid && full_q) begin
                  overflow_d = 1'b1;
               end else if (bus.note_valid) begin
                  // A note beats a same-cycle tick: it takes the pre-tick gap.
                  wr_en   = 1'b1;
                  wr_gap  = (state_q == S_ARMED) ? '0 : gap_q;
                  track_d = track_q + 1'b1;
                  gap_d   = '0;
                  state_d = (bus.stop || track_q == TRACK_LAST) ? S_DONE : S_RECORD;
               end else if (bus.stop) begin
                  state_d = S_DONE;
               end else if (bus.tick && state_q == S_RECORD) begin
                  if (gap_q == GAP_MAX) state_d = S_DONE;
                  else                  gap_d   = gap_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      full_d = (track_d == TRACK_FULL);
   end

   assign wr_data = {bus.octave, bus.note, bus.length, wr_gap};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         track_q    <= '0;
         gap_q      <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         track_q    <= track_d;
         gap_q      <= gap_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[track_q[ADDR_BITS-1:0]] <= wr_data;
   end

   // Entries past the end of the take read as a rest so playback stops cleanly.
   assign rd_entry = mem[bus.rd_addr];
   assign rd_hit   = ({1'b0, bus.rd_addr} < track_q);

   assign bus.rd_octave = rd_hit ? rd_entry[ENTRY_BITS-1 -: OCTAVE_BITS] : '0;
   assign bus.rd_note   = rd_hit ? rd_entry[GAP_BITS+LENGTH_BITS +: NOTE_BITS] : '0;
   assign bus.rd_length = rd_hit ? rd_entry[GAP_BITS +: LENGTH_BITS] : '0;
   assign bus.rd_gap    = rd_hit ? rd_entry[GAP_BITS-1:0] : '0;

   assign bus.track    = track_q;
   assign bus.state    = state_q;
   assign bus.full     = full_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_song_recorder.sv
// Randomized and directed bench for song_recorder against a take-level reference model.
module tb_song_recorder;
   localparam int DEPTH   = 64;
   localparam int GAP_MAX = 255;
   localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RECORD = 2, ST_DONE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   song_recorder_if bus ();

   song_recorder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the take as a list of entries plus the recorder's mode.
   int m_state, m_track, m_gap;
   bit m_ovf;
   int m_entry [DEPTH];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic int pack_entry(input int o, input int n, input int l, input int g);
      return (o << 14) | (n << 11) | (l << 8) | g;
   endfunction

   function automatic void model_reset();
      m_state = ST_IDLE; m_track = 0; m_gap = 0; m_ovf = 0;
   endfunction

   function automatic void model_step(input bit en, input bit st, input bit sp, input bit tk,
                                      input bit nv, input int o, input int n, input int l);
      bit is_full = (m_track == DEPTH);
      if (!en) begin
         m_state = ST_IDLE;
         if (nv && is_full) m_ovf = 1;
         return;
      end
      if (m_state == ST_IDLE || m_state == ST_DONE) begin
         if (st) begin
            m_state = ST_ARMED; m_track = 0; m_ovf = 0; m_gap = 0;
         end else if (nv && is_full) m_ovf = 1;
      end else begin
         if (nv && is_full) m_ovf = 1;
         else if (nv) begin
            m_entry[m_track] = pack_entry(o, n, l, (m_state == ST_ARMED) ? 0 : m_gap);
            m_track++;
            m_gap = 0;
            m_state = (sp || m_track == DEPTH) ? ST_DONE : ST_RECORD;
         end else if (sp) m_state = ST_DONE;
         else if (tk && m_state == ST_RECORD) begin
            if (m_gap == GAP_MAX) m_state = ST_DONE;
            else m_gap++;
         end
      end
   endfunction

   task automatic read_check(input int a);
      int exp;
      bus.rd_addr = a[5:0];
      #1;
      exp = (a < m_track) ? m_entry[a] : 0;
      check_eq($sformatf("rd[%0d]", a),
               int'({bus.rd_octave, bus.rd_note, bus.rd_length, bus.rd_gap}), exp);
   endtask

   task automatic check_status();
      check_eq("state", int'(bus.state), m_state);
      check_eq("track", int'(bus.track), m_track);
      check_eq("full", int'(bus.full), int'(m_track == DEPTH));
      check_eq("overflow", int'(bus.overflow), int'(m_ovf));
   endtask

   task automatic step_f(input bit en, input bit st, input bit sp, input bit tk, input bit nv,
                         input int o, input int n, input int l);
      bus.en = en; bus.start = st; bus.stop = sp; bus.tick = tk; bus.note_valid = nv;
      bus.octave = o[2:0]; bus.note = n[2:0]; bus.length = l[2:0];
      @(posedge clk);
      model_step(en, st, sp, tk, nv, o, n, l);
      #1;
      bus.start = 0; bus.stop = 0; bus.tick = 0; bus.note_valid = 0;
      check_status();
      read_check($urandom_range(0, DEPTH - 1));
   endtask

   task automatic step(input bit en, input bit st, input bit sp, input bit tk, input bit nv);
      step_f(en, st, sp, tk, nv, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
   endtask

   initial begin
      bus.en = 0; bus.start = 0; bus.stop = 0; bus.tick = 0; bus.note_valid = 0;
      bus.octave = 0; bus.note = 0; bus.length = 0; bus.rd_addr = 0;
      model_reset();
      #12;
      check_status();
      read_check(0);
      #6 rst_n = 1'b1;

      // Basic take: two notes three ticks apart.
      step(1, 1, 0, 0, 0);
      step_f(1, 0, 0, 0, 1, 4, 1, 2);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
      step_f(1, 0, 0, 0, 1, 4, 5, 2);
      step(1, 0, 1, 0, 0);
      check_eq("t1_state", int'(bus.state), ST_DONE);
      check_eq("t1_track", int'(bus.track), 2);
      bus.rd_addr = 0; #1;
      check_eq("t1_e0", int'({bus.rd_octave, bus.rd_note, bus.rd_length, bus.rd_gap}), pack_entry(4, 1, 2, 0));
      bus.rd_addr = 1; #1;
      check_eq("t1_e1", int'({bus.rd_octave, bus.rd_note, bus.rd_length, bus.rd_gap}), pack_entry(4, 5, 2, 3));
      read_check(2);

      // Idle timeout: gap saturates, then the next tick ends the take.
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 256; i++) step(1, 0, 0, 1, 0);
      check_eq("sat_state", int'(bus.state), ST_DONE);
      check_eq("sat_track", int'(bus.track), 1);

      // Gap carry-over when a note and a tick coincide.
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 1);
      for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1);
      bus.rd_addr = 1; #1;
      check_eq("tick_e1_gap", int'(bus.rd_gap), 5);
      bus.rd_addr = 2; #1;
      check_eq("tick_e2_gap", int'(bus.rd_gap), 2);

      // Fill the buffer, then overflow, then clear with a fresh start.
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, $urandom_range(0, 1), 1);
      check_eq("fill_full", int'(bus.full), 1);
      check_eq("fill_state", int'(bus.state), ST_DONE);
      step(1, 0, 0, 0, 1);
      check_eq("ovf_set", int'(bus.overflow), 1);
      check_eq("ovf_track", int'(bus.track), DEPTH);
      for (int a = 0; a < DEPTH; a += 9) read_check(a);
      step(1, 1, 0, 0, 0);
      check_eq("ovf_clear", int'(bus.overflow), 0);
      check_eq("restart_track", int'(bus.track), 0);

      // en dropped mid-take: contents kept, later notes ignored.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      check_eq("en_state", int'(bus.state), ST_IDLE);
      check_eq("en_track", int'(bus.track), 3);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      for (int a = 0; a < 4; a++) read_check(a);

      // Asynchronous reset mid-record, observed before any clock edge.
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("arst_state", int'(bus.state), ST_IDLE);
      check_eq("arst_track", int'(bus.track), 0);
      read_check(0);
      #3 rst_n = 1'b1;

      // Random mix of all controls.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 25);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
